nim_turn_ctrl: RTL
==================

Name: nim_turn_ctrl

Overview:
Central game sequencer for the Nim board.
- Holds the stick count of the four rows (1/3/5/7 at start) and tracks whose turn it is.
- Enforces the single-row-per-turn rule and drives the step-motor turn pointer through a req/ack handshake.
- Detects game over (misère: the player taking the last stick loses) and keeps per-player scores for the 7-seg display path.
- Inputs are one-cycle pulses from the upstream button synchronizers; outputs feed the 7-seg, 8x8 LED and step-motor drivers.

Parameters:
MAX_SCORE, 9, score saturation value per player
SCORE_W, 4, score register width (must hold MAX_SCORE)
TIMEOUT_CYC, 500000000, idle cycles before forced handover (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
sel_row  in  4  one-cycle pulses; bit i = take one stick from row i+1
chg_p  in  1  one-cycle pulse: end current turn
new_game  in  1  one-cycle pulse: reload board
motor_ack  in  1  step-motor move complete, level held until motor_req drops
row1..row4  out  3 each  sticks left per row
sticks_left  out  5  total sticks left (0..16)
cur_player  out  1  0 = left, 1 = right
row_lock  out  3  0 = none, 1..4 = row locked this turn
motor_req  out  1  request pointer move
motor_dir  out  1  target player for motor
game_over  out  1  level, high in GAME_OVER state
winner  out  1  valid while game_over
score_l, score_r  out  SCORE_W each  wins per player
illegal_mv  out  1  one-cycle pulse on rejected input

Behaviour:
- Reset (rst=0, async):
  - Outputs: rows 1/3/5/7, sticks_left=16, cur_player=0, row_lock=0, motor_req=0, motor_dir=0, game_over=0, winner=0, scores=0, illegal_mv=0.
  - State TURN_START.
- States: TURN_START, TURN_TAKE, MOTOR_WAIT, GAME_OVER. All registered; outputs update the cycle after the input pulse.
- sel_row validity:
  - Exactly one bit set, otherwise the input is ignored and illegal_mv pulses.
  - Target row nonzero, otherwise ignored and illegal_mv pulses.
  - In TURN_TAKE only, target row must equal row_lock, otherwise ignored and illegal_mv pulses.
  - sel_row is ignored without illegal_mv in MOTOR_WAIT and GAME_OVER.
- TURN_START + valid sel: decrement the row and sticks_left; row_lock = row index; go to TURN_TAKE.
- TURN_TAKE + valid sel: decrement the row and sticks_left.
- Game-over check on any sel that takes sticks_left from 1 to 0:
  - Next state GAME_OVER; winner = ~cur_player.
  - Winner's score increments, saturating at MAX_SCORE.
  - row_lock cleared; no motor move.
- chg_p:
  - In TURN_TAKE: motor_req=1, motor_dir=~cur_player, row_lock=0; go to MOTOR_WAIT.
  - In TURN_START: ignored and illegal_mv pulses (a player must take at least one stick).
  - In all other states: ignored.
- sel_row and chg_p in the same cycle: sel is processed, chg_p is dropped.
- MOTOR_WAIT:
  - motor_req and motor_dir are held until motor_ack=1 is sampled.
  - Next cycle: motor_req=0, cur_player=motor_dir, state TURN_START.
  - motor_ack outside MOTOR_WAIT is ignored.
- new_game:
  - In GAME_OVER, TURN_START or TURN_TAKE: reload rows to 1/3/5/7, sticks_left=16, row_lock=0, game_over=0; state TURN_START.
  - Scores and cur_player are kept, so the loser starts the next game.
  - In MOTOR_WAIT: ignored.
  - Same cycle as sel or chg_p: new_game wins and the other pulses are dropped.
- Invariant: sticks_left always equals the sum of row1..row4. No underflow is possible.

Optional Feature:
Macro NIM_TURN_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in TURN_TAKE and clears on every accepted sel or state exit.
  - At count TIMEOUT_CYC-1 the block behaves exactly as for chg_p (handover to MOTOR_WAIT).
  - No timeout in TURN_START.
- Undefined: no counter; a turn only ends by chg_p or game over. TIMEOUT_CYC is unused.

Test Plan:
- Reset, sel_row=0001, sel_row=0100 → row1=0, row3=5, sticks_left=15, illegal_mv pulses once, row_lock=1.
- sel_row=1000 x3, chg_p, hold motor_ack low 10 cycles then high → row4=4, motor_req high throughout wait with motor_dir=1, then cur_player=1, state TURN_START.
- Empty the board to 1 stick, right player takes it → game_over=1, winner=0, score_l=1; following sel/chg_p have no effect.
- chg_p in TURN_START → illegal_mv pulse, no motor_req; sel_row=0011 → illegal_mv, rows unchanged.
- MAX_SCORE=2, three left wins → score_l=2 saturates; new_game reloads 1/3/5/7, scores kept; async rst mid MOTOR_WAIT → all outputs at reset values immediately.
- NIM_TURN_TIMEOUT_EN defined, TIMEOUT_CYC=20: one sel then idle → motor_req rises on cycle 20 after the sel; a sel at cycle 15 restarts the count.

Source files
------------

// File: rtl/nim_turn_ctrl.sv
// Nim turn sequencer: board state, turn/row-lock rules, misere game over, scores; NIM_TURN_TIMEOUT_EN adds an idle-turn timeout.
// All outputs registered (1-cycle latency); motor_req/motor_dir held until motor_ack, no other backpressure.
module nim_turn_ctrl #(
  parameter int MAX_SCORE = 9,
  parameter int SCORE_W   = 4
`ifdef NIM_TURN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 500000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         sel_row,
  input  logic               chg_p,
  input  logic               new_game,
  input  logic               motor_ack,
  output logic [2:0]         row1,
  output logic [2:0]         row2,
  output logic [2:0]         row3,
  output logic [2:0]         row4,
  output logic [4:0]         sticks_left,
  output logic               cur_player,
  output logic [2:0]         row_lock,
  output logic               motor_req,
  output logic               motor_dir,
  output logic               game_over,
  output logic               winner,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               illegal_mv
);

  typedef enum logic [1:0] {TURN_START, TURN_TAKE, MOTOR_WAIT, GAME_OVER} state_t;

  state_t               state_q, state_d;
  logic [2:0]           row_q [4];
  logic [2:0]           row_d [4];
  logic [4:0]           sticks_q, sticks_d;
  logic                 cur_player_q, cur_player_d;
  logic [2:0]           row_lock_q, row_lock_d;
  logic                 motor_req_q, motor_req_d;
  logic                 motor_dir_q, motor_dir_d;
  logic                 game_over_q, game_over_d;
  logic                 winner_q, winner_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic                 illegal_q, illegal_d;
`ifdef NIM_TURN_TIMEOUT_EN
  logic [31:0]          cnt_q, cnt_d;
`endif

  logic [1:0] sel_idx;
  logic       sel_one_hot;
  logic       sel_ok;
  logic       do_reload, do_take, do_handover;

  always_comb begin
    sel_one_hot = 1'b1;
    sel_idx     = 2'd0;
    case (sel_row)
      4'b0001: sel_idx = 2'd0;
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_one_hot = 1'b0;
    endcase
    // Once a row has been touched this turn, only that row may be taken from.
    sel_ok = sel_one_hot && (row_q[sel_idx] != 3'd0) &&
             ((state_q != TURN_TAKE) || (row_lock_q == ({1'b0, sel_idx} + 3'd1)));
  end

  always_comb begin
    state_d      = state_q;
    for (int i = 0; i < 4; i++) row_d[i] = row_q[i];
    sticks_d     = sticks_q;
    cur_player_d = cur_player_q;
    row_lock_d   = row_lock_q;
    motor_req_d  = motor_req_q;
    motor_dir_d  = motor_dir_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    illegal_d    = 1'b0;
    do_reload    = 1'b0;
    do_take      = 1'b0;
    do_handover  = 1'b0;

    case (state_q)
      TURN_START, TURN_TAKE: begin
        if (new_game) begin
          do_reload = 1'b1;
        end else if (sel_row != 4'd0) begin
          if (sel_ok) do_take = 1'b1;
          else        illegal_d = 1'b1;
        end else if (chg_p) begin
          if (state_q == TURN_TAKE) do_handover = 1'b1;
          else                      illegal_d = 1'b1;
        end
`ifdef NIM_TURN_TIMEOUT_EN
        else if ((state_q == TURN_TAKE) && (cnt_q >= 32'(TIMEOUT_CYC - 1))) begin
          do_handover = 1'b1;
        end
`endif
      end
      MOTOR_WAIT: begin
        if (motor_ack) begin
          motor_req_d  = 1'b0;
          cur_player_d = motor_dir_q;
          state_d      = TURN_START;
        end
      end
      GAME_OVER: begin
        if (new_game) do_reload = 1'b1;
      end
      default: state_d = TURN_START;
    endcase

    if (do_reload) begin
      row_d[0]    = 3'd1;
      row_d[1]    = 3'd3;
      row_d[2]    = 3'd5;
      row_d[3]    = 3'd7;
      sticks_d    = 5'd16;
      row_lock_d  = 3'd0;
      game_over_d = 1'b0;
      state_d     = TURN_START;
    end

    if (do_take) begin
      row_d[sel_idx] = row_q[sel_idx] - 3'd1;
      sticks_d       = sticks_q - 5'd1;
      if (sticks_q == 5'd1) begin
        // Misere: whoever empties the board loses.
        state_d     = GAME_OVER;
        game_over_d = 1'b1;
        winner_d    = ~cur_player_q;
        row_lock_d  = 3'd0;
        if (cur_player_q) begin
          if (score_l_q < SCORE_W'(MAX_SCORE)) score_l_d = score_l_q + 1'b1;
        end else begin
          if (score_r_q < SCORE_W'(MAX_SCORE)) score_r_d = score_r_q + 1'b1;
        end
      end else begin
        row_lock_d = {1'b0, sel_idx} + 3'd1;
        state_d    = TURN_TAKE;
      end
    end

    if (do_handover) begin
      motor_req_d = 1'b1;
      motor_dir_d = ~cur_player_q;
      row_lock_d  = 3'd0;
      state_d     = MOTOR_WAIT;
    end
  end

`ifdef NIM_TURN_TIMEOUT_EN
  // Idle cycles in TURN_TAKE; ignored/illegal inputs still count as idle.
  always_comb begin
    cnt_d = 32'd0;
    if ((state_q == TURN_TAKE) && (state_d == TURN_TAKE) && !do_take) cnt_d = cnt_q + 32'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TURN_START;
      row_q[0]     <= 3'd1;
      row_q[1]     <= 3'd3;
      row_q[2]     <= 3'd5;
      row_q[3]     <= 3'd7;
      sticks_q     <= 5'd16;
      cur_player_q <= 1'b0;
      row_lock_q   <= 3'd0;
      motor_req_q  <= 1'b0;
      motor_dir_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      illegal_q    <= 1'b0;
`ifdef NIM_TURN_TIMEOUT_EN
      cnt_q        <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < 4; i++) row_q[i] <= row_d[i];
      sticks_q     <= sticks_d;
      cur_player_q <= cur_player_d;
      row_lock_q   <= row_lock_d;
      motor_req_q  <= motor_req_d;
      motor_dir_q  <= motor_dir_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      illegal_q    <= illegal_d;
`ifdef NIM_TURN_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign row1        = row_q[0];
  assign row2        = row_q[1];
  assign row3        = row_q[2];
  assign row4        = row_q[3];
  assign sticks_left = sticks_q;
  assign cur_player  = cur_player_q;
  assign row_lock    = row_lock_q;
  assign motor_req   = motor_req_q;
  assign motor_dir   = motor_dir_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign illegal_mv  = illegal_q;

endmodule
